// File: rtl/demux16_tdm_pkg.sv
// Shared defaults and types for the 16-slot TDM receive demultiplexer.
package demux16_tdm_pkg;

    localparam int NCH_DEF   = 16;
    localparam int SEL_W_DEF = $clog2(NCH_DEF);

    typedef logic [SEL_W_DEF-1:0] slot_idx_t;
    typedef logic [NCH_DEF-1:0]   frame_t;

endpackage

// File: rtl/demux16_tdm_if.sv
// Serial-in / frame-out bundle between the TDM link, the demux and its consumer.
interface demux16_tdm_if
    import demux16_tdm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = $clog2(NCH)
);
    logic             din;
    logic             din_valid;
    logic             sof;
    logic [SEL_W-1:0] slot;
    logic [NCH-1:0]   dout;
    logic             out_valid;
    logic             out_ready;
    logic             ovf;
    logic             sync_err;

    modport master (
        output din, din_valid, sof, out_ready,
        input  slot, dout, out_valid, ovf, sync_err
    );

    modport slave (
        input  din, din_valid, sof, out_ready,
        output slot, dout, out_valid, ovf, sync_err
    );
endinterface

// File: rtl/demux16_tdm_slot_ctr.sv
// Slot counter (the receive-side select lines): advances on valid bits, restarts on sof.
module tdm_slot_ctr
    import demux16_tdm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             sof,
    output logic [SEL_W-1:0] slot,
    output logic             last_slot,
    output logic             mid_frame_sof
);
    logic [SEL_W-1:0] slot_reg;
    logic [SEL_W-1:0] slot_next;

    assign slot          = slot_reg;
    assign last_slot     = (slot_reg == SEL_W'(NCH - 1));
    assign mid_frame_sof = din_valid && sof && (slot_reg != '0);

    always_comb begin
        slot_next = slot_reg;
        if (din_valid) begin
            if (sof) begin
                // The sof bit itself occupies slot 0, so the next bit lands in slot 1.
                slot_next = SEL_W'(1);
            end else begin
                slot_next = slot_reg + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end
endmodule

// File: rtl/demux16_tdm.sv
// TDM serial-to-parallel demultiplexer with a single-entry valid/ready output stage.
module demux16_tdm
    import demux16_tdm_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int SEL_W = $clog2(NCH)
) (
    input logic           clk,
    input logic           rst,
    demux16_tdm_if.slave  bus
);
    logic [SEL_W-1:0] slot;
    logic             last_slot;
    logic             mid_frame_sof;

    logic [NCH-1:0] asm_reg, asm_next;
    logic [NCH-1:0] dout_reg, dout_next;
    logic [NCH-1:0] candidate;
    logic           out_valid_reg, out_valid_next;
    logic           ovf_reg, ovf_next;
    logic           sync_err_reg, sync_err_next;
    logic           complete;
    logic           load;

    tdm_slot_ctr #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_slot_ctr (
        .clk           (clk),
        .rst           (rst),
        .din_valid     (bus.din_valid),
        .sof           (bus.sof),
        .slot          (slot),
        .last_slot     (last_slot),
        .mid_frame_sof (mid_frame_sof)
    );

    // Each assembly bit captures din when its slot is addressed; sof always targets bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_asm
            localparam bit IS_FIRST = (gi == 0);
            logic hit;
            assign hit = bus.din_valid && (bus.sof ? IS_FIRST : (slot == SEL_W'(gi)));
            assign asm_next[gi] = hit ? bus.din : asm_reg[gi];
        end
    endgenerate

    // The final bit is taken straight from din so the frame lands one cycle after it.
    assign candidate = {bus.din, asm_reg[NCH-2:0]};
    assign complete  = bus.din_valid && !bus.sof && last_slot;
    assign load      = complete && (!out_valid_reg || bus.out_ready);

    always_comb begin
        dout_next      = dout_reg;
        out_valid_next = out_valid_reg;
        ovf_next       = complete && out_valid_reg && !bus.out_ready;
        sync_err_next  = mid_frame_sof;
        if (load) begin
            dout_next      = candidate;
            out_valid_next = 1'b1;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_reg       <= '0;
            dout_reg      <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            asm_reg       <= asm_next;
            dout_reg      <= dout_next;
            out_valid_reg <= out_valid_next;
            ovf_reg       <= ovf_next;
            sync_err_reg  <= sync_err_next;
        end
    end

    assign bus.slot      = slot;
    assign bus.dout      = dout_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.sync_err  = sync_err_reg;
endmodule

// File: tb/tb_demux16_tdm.sv
// Self-checking bench for demux16_tdm: frame table, directed corner cases, random traffic vs. a model.
module tb_demux16_tdm;
    import demux16_tdm_pkg::*;

    localparam int NCH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux16_tdm_if #(.NCH(NCH)) bus ();

    demux16_tdm #(.NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame-in-progress bit array plus a one-deep output holding slot.
    int          m_pos;
    bit          m_bits[NCH];
    logic [15:0] m_dout;
    bit          m_valid;
    bit          m_ovf;
    bit          m_serr;

    typedef struct {
        logic [15:0] frame;
        int          gap;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("slot",      32'(bus.slot),      32'(m_pos));
        check("dout",      32'(bus.dout),      32'(m_dout));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("ovf",       32'(bus.ovf),       32'(m_ovf));
        check("sync_err",  32'(bus.sync_err), 32'(m_serr));
    endtask

    task automatic model_reset();
        m_pos   = 0;
        for (int k = 0; k < NCH; k++) m_bits[k] = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_serr  = 1'b0;
    endtask

    // One input cycle seen from the protocol description, not from the RTL's registers.
    task automatic model_cycle(input bit din, input bit dv, input bit sof, input bit rdy);
        bit          loaded;
        logic [15:0] word;
        loaded = 1'b0;
        m_ovf  = 1'b0;
        m_serr = 1'b0;
        if (dv) begin
            if (sof) begin
                m_serr    = (m_pos != 0);
                m_bits[0] = din;
                m_pos     = 1;
            end else begin
                m_bits[m_pos] = din;
                if (m_pos == NCH - 1) begin
                    for (int k = 0; k < NCH; k++) word[k] = m_bits[k];
                    if (!m_valid || rdy) begin
                        m_dout = word;
                        loaded = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_pos = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
        if (loaded)              m_valid = 1'b1;
        else if (m_valid && rdy) m_valid = 1'b0;
    endtask

    task automatic step(input bit din, input bit dv, input bit sof, input bit rdy);
        bus.din       = din;
        bus.din_valid = dv;
        bus.sof       = sof;
        bus.out_ready = rdy;
        model_cycle(din, dv, sof, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        $display("reset: slot=%0d out_valid=%0b dout=0x%04h", bus.slot, bus.out_valid, bus.dout);
    endtask

    task automatic send_frame(input logic [15:0] w, input int gap, input bit rdy, input bit last_rdy);
        for (int k = 0; k < NCH; k++) begin
            for (int g = 0; g < gap; g++) step(1'($urandom), 1'b0, 1'($urandom), rdy);
            step(w[k], 1'b1, (k == 0), (k == NCH - 1) ? last_rdy : rdy);
        end
        $display("frame 0x%04h gap=%0d -> dout=0x%04h out_valid=%0b ovf=%0b",
                 w, gap, bus.dout, bus.out_valid, bus.ovf);
    endtask

    initial begin
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{16'hA5C3, 0, 16'hA5C3};
        vecs[1] = '{16'hA5C3, 2, 16'hA5C3};
        vecs[2] = '{16'h0000, 1, 16'h0000};
        vecs[3] = '{16'hFFFF, 0, 16'hFFFF};
        vecs[4] = '{16'h6E19, 3, 16'h6E19};

        do_reset();
        check("rst_slot",  32'(bus.slot),      32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dout",  32'(bus.dout),      32'h0);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].frame, vecs[i].gap, 1'b1, 1'b1);
            check("tbl_dout",  32'(bus.dout),      32'(vecs[i].exp_dout));
            check("tbl_valid", 32'(bus.out_valid), 32'd1);
            check("tbl_slot",  32'(bus.slot),      32'd0);
        end

        // Overrun: consumer stalled across two complete frames.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(16'h1234, 0, 1'b0, 1'b0);
        send_frame(16'hFFFF, 0, 1'b0, 1'b0);
        check("ovf_pulse", 32'(bus.ovf),       32'd1);
        check("ovf_hold",  32'(bus.dout),      32'h1234);
        check("ovf_valid", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovf_once",  32'(bus.ovf),       32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // Simultaneous accept and load keeps out_valid high.
        send_frame(16'h0001, 0, 1'b0, 1'b0);
        check("hold_dout", 32'(bus.dout), 32'h0001);
        send_frame(16'h8000, 0, 1'b0, 1'b1);
        check("swap_valid", 32'(bus.out_valid), 32'd1);
        check("swap_dout",  32'(bus.dout),      32'h8000);
        check("swap_ovf",   32'(bus.ovf),       32'd0);

        // Mid-frame sof after 7 bits restarts the frame.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) step(1'b1, 1'b1, (k == 0), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("serr_pulse", 32'(bus.sync_err), 32'd1);
        check("serr_slot",  32'(bus.slot),     32'd1);
        check("serr_noout", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1);
            if (k == 0) check("serr_once", 32'(bus.sync_err), 32'd0);
        end
        check("resync_dout",  32'(bus.dout),      32'h0001);
        check("resync_valid", 32'(bus.out_valid), 32'd1);
        $display("resync frame -> dout=0x%04h", bus.dout);

        // Reset in slot 9 with a frame pending.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b1, 1'b1, (k == 0), 1'b0);
        check("pre_rst_slot",  32'(bus.slot),      32'd9);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        do_reset();
        check("mid_rst_slot",  32'(bus.slot),      32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_dout",  32'(bus.dout),      32'h0);
        send_frame(16'h5A5A, 0, 1'b1, 1'b1);
        check("post_rst_dout", 32'(bus.dout), 32'h5A5A);

        // Random traffic: sparse valids, occasional sof (also without valid), random backpressure.
        for (int c = 0; c < 800; c++) begin
            step(1'($urandom), ($urandom % 4) != 0, ($urandom % 12) == 0, 1'($urandom));
            if (bus.ovf || bus.sync_err || (c % 100 == 0))
                $display("rand cycle %0d: slot=%0d dout=0x%04h out_valid=%0b ovf=%0b sync_err=%0b",
                         c, bus.slot, bus.dout, bus.out_valid, bus.ovf, bus.sync_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
